// File: rtl/diag_func_sequencer_if.sv
//-----------------------------------------------------------------------------
// diag_func_sequencer_if
//
// Groups the front-end command handshake and the EBUS diagnostic signals of
// the diag_func_sequencer into one bundle.
//
//   master : front end (issues commands and master-reset requests)
//   slave  : the sequencer (drives the EBUS diagnostic lines and status)
//
// Signals
//   cmdValid    front end requests a single diagnostic function
//   cmdReady    sequencer can accept a command
//   cmdFunc     diagnostic function code, octal 000-177
//   cmdData     EBUS data for load-type functions
//   cmdDataEn   drive cmdData onto the EBUS during the strobe
//   mrStart     one-clk pulse requesting the master-reset sequence
//   ds          EBUS.ds[0:6]
//   diagStrobe  EBUS.diagStrobe
//   ebusData    EBUS data value
//   ebusDrive   EBUS data driver enable
//   busy        sequencer active or master reset pending
//   mrBusy      master-reset sequence in progress or pending
//   done        one-clk pulse per completed function
//   mrDone      one-clk pulse when the last master-reset step completes
//-----------------------------------------------------------------------------
`timescale 1ns/1ps

interface diag_func_sequencer_if;
  logic        cmdValid;
  logic        cmdReady;
  logic [6:0]  cmdFunc;
  logic [35:0] cmdData;
  logic        cmdDataEn;
  logic        mrStart;

  logic [6:0]  ds;
  logic        diagStrobe;
  logic [35:0] ebusData;
  logic        ebusDrive;
  logic        busy;
  logic        mrBusy;
  logic        done;
  logic        mrDone;

  modport master (
    output cmdValid, cmdFunc, cmdData, cmdDataEn, mrStart,
    input  cmdReady, ds, diagStrobe, ebusData, ebusDrive,
           busy, mrBusy, done, mrDone
  );

  modport slave (
    input  cmdValid, cmdFunc, cmdData, cmdDataEn, mrStart,
    output cmdReady, ds, diagStrobe, ebusData, ebusDrive,
           busy, mrBusy, done, mrDone
  );
endinterface

// File: rtl/diag_func_sequencer.sv
//-----------------------------------------------------------------------------
// diag_func_sequencer
//
// Front-end sequencer for EBUS diagnostic functions. Each function is issued
// as: wait for the next MHZ16 tick, raise diagStrobe with ds (and optionally
// EBUS data) for STROBE_TICKS tick periods, release the bus, keep it idle for
// GAP_TICKS tick periods, then pulse done. A built-in ROM provides the
// master-reset sequence (stop clock, clear source/rate, reset parity, clear
// burst counter and CRAM diagnostic address).
//
// Parameters
//   STROBE_TICKS  tick periods diagStrobe is held high (>= 1)
//   GAP_TICKS     idle tick periods after strobe release (>= 0)
//   CNT_W         tick counter width, must hold max(STROBE_TICKS, GAP_TICKS)
//
// Ports
//   clk       EBOX master clock
//   CROBAR_N  asynchronous active-low reset
//   tick16    one-clk pulse per MHZ16 period (falling edge of MHZ16_FREE)
//   bus       diag_func_sequencer_if.slave: command handshake, master-reset
//             request, EBUS ds/diagStrobe/data outputs and status pulses
//
// Build option
//   DIAG_SEQ_KL_ENABLE_EN  when defined, the master-reset ROM is extended with
//                          067 ENABLE_KL and 076 EBUS_LOAD (11 steps);
//                          otherwise it has 9 steps ending at 051.
//-----------------------------------------------------------------------------
`timescale 1ns/1ps

module diag_func_sequencer #(
  parameter int STROBE_TICKS = 9,
  parameter int GAP_TICKS    = 4,
  parameter int CNT_W        = 4
) (
  input  logic                 clk,
  input  logic                 CROBAR_N,
  input  logic                 tick16,
  diag_func_sequencer_if.slave bus
);

`ifdef DIAG_SEQ_KL_ENABLE_EN
  localparam int ROM_LEN = 11;
`else
  localparam int ROM_LEN = 9;
`endif
  localparam int STEP_W = 4;
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(ROM_LEN - 1);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
    GAP,
    FINISH
  } state_t;

  // Master-reset sequence, issued in index order.
  function automatic logic [6:0] rom_func(input logic [STEP_W-1:0] idx);
    case (idx)
      4'd0:    rom_func = 7'o007;  // SET_RESET
      4'd1:    rom_func = 7'o006;  // CLR_RESET
      4'd2:    rom_func = 7'o000;  // STOP_CLOCK
      4'd3:    rom_func = 7'o044;  // CLR_CLK_SRC_RATE
      4'd4:    rom_func = 7'o046;  // RESET_PAR_REGS
      4'd5:    rom_func = 7'o042;  // CLR_BURST_CTR_RH
      4'd6:    rom_func = 7'o043;  // CLR_BURST_CTR_LH
      4'd7:    rom_func = 7'o052;  // CLR_CRAM_DIAG_ADR_LH
      4'd8:    rom_func = 7'o051;  // CLR_CRAM_DIAG_ADR_RH
`ifdef DIAG_SEQ_KL_ENABLE_EN
      4'd9:    rom_func = 7'o067;  // ENABLE_KL
      4'd10:   rom_func = 7'o076;  // EBUS_LOAD
`endif
      default: rom_func = 7'o000;
    endcase
  endfunction

  // State and datapath registers (_q) with their next values (_d).
  state_t              state_q,      state_d;
  logic [STEP_W-1:0]   step_q,       step_d;
  logic [CNT_W-1:0]    cnt_q,        cnt_d;
  logic                is_rom_q,     is_rom_d;
  logic                mr_pending_q, mr_pending_d;
  logic                mr_busy_q,    mr_busy_d;
  logic [6:0]          func_q,       func_d;
  logic [35:0]         data_q,       data_d;
  logic                data_en_q,    data_en_d;
  logic [6:0]          ds_q,         ds_d;
  logic                strobe_q,     strobe_d;
  logic [35:0]         ebus_data_q,  ebus_data_d;
  logic                ebus_drive_q, ebus_drive_d;
  logic                done_q,       done_d;
  logic                mr_done_q,    mr_done_d;

  logic [CNT_W-1:0]    cnt_next;
  logic                last_step;
  logic                cmd_ready;

  assign cnt_next  = cnt_q + 1'b1;
  assign last_step = is_rom_q && (step_q == LAST_STEP);
  // A pending master reset blocks new commands even while IDLE.
  assign cmd_ready = (state_q == IDLE) && !mr_pending_q;

  //---------------------------------------------------------------------------
  // Next-state and output logic
  //---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every next value defaults to its current register (pulses to 0)
    // before any branch, so no path leaves a variable unassigned and no
    // latch is inferred.
    state_d      = state_q;
    step_d       = step_q;
    cnt_d        = cnt_q;
    is_rom_d     = is_rom_q;
    mr_pending_d = mr_pending_q;
    mr_busy_d    = mr_busy_q;
    func_d       = func_q;
    data_d       = data_q;
    data_en_d    = data_en_q;
    ds_d         = ds_q;
    strobe_d     = strobe_q;
    ebus_data_d  = ebus_data_q;
    ebus_drive_d = ebus_drive_q;
    done_d       = 1'b0;
    mr_done_d    = 1'b0;

    // A master-reset request that arrives while working is remembered and
    // served on the next return to IDLE; repeats collapse into one.
    if (bus.mrStart && (state_q != IDLE)) begin
      mr_pending_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (bus.mrStart || mr_pending_q) begin
          // Master reset takes priority over a simultaneous command.
          mr_pending_d = 1'b0;
          mr_busy_d    = 1'b1;
          is_rom_d     = 1'b1;
          step_d       = '0;
          func_d       = rom_func('0);
          data_d       = '0;
          data_en_d    = 1'b0;
          state_d      = SETUP;
        end else if (bus.cmdValid && cmd_ready) begin
          is_rom_d     = 1'b0;
          func_d       = bus.cmdFunc;
          data_d       = bus.cmdData;
          data_en_d    = bus.cmdDataEn;
          state_d      = SETUP;
        end
      end

      SETUP: begin
        // Entered the clk after acceptance, so a tick coincident with
        // acceptance is never mistaken for the launch tick.
        if (tick16) begin
          ds_d         = func_q;
          ebus_data_d  = data_en_q ? data_q : '0;
          ebus_drive_d = data_en_q;
          strobe_d     = 1'b1;
          cnt_d        = '0;
          state_d      = STROBE;
        end
      end

      STROBE: begin
        if (tick16) begin
          if (cnt_next == CNT_W'(STROBE_TICKS)) begin
            // Release strobe, code and data together on the same tick.
            ds_d         = '0;
            strobe_d     = 1'b0;
            ebus_data_d  = '0;
            ebus_drive_d = 1'b0;
            cnt_d        = '0;
            if (GAP_TICKS == 0) begin
              done_d    = 1'b1;
              mr_done_d = last_step;
              state_d   = FINISH;
            end else begin
              state_d   = GAP;
            end
          end else begin
            cnt_d = cnt_next;
          end
        end
      end

      GAP: begin
        if (tick16) begin
          if (cnt_next == CNT_W'(GAP_TICKS)) begin
            cnt_d     = '0;
            done_d    = 1'b1;
            mr_done_d = last_step;
            state_d   = FINISH;
          end else begin
            cnt_d = cnt_next;
          end
        end
      end

      FINISH: begin
        // done/mrDone are registered on entry, so they are high exactly
        // during this single clk.
        if (is_rom_q && !last_step) begin
          step_d  = step_q + 1'b1;
          func_d  = rom_func(step_q + 1'b1);
          state_d = SETUP;
        end else begin
          if (is_rom_q) begin
            mr_busy_d = 1'b0;
          end
          is_rom_d = 1'b0;
          state_d  = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  //---------------------------------------------------------------------------
  // State register
  //---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge CROBAR_N) begin
    if (!CROBAR_N) begin
      state_q      <= IDLE;
      step_q       <= '0;
      cnt_q        <= '0;
      is_rom_q     <= 1'b0;
      mr_pending_q <= 1'b0;
      mr_busy_q    <= 1'b0;
      func_q       <= '0;
      data_q       <= '0;
      data_en_q    <= 1'b0;
      ds_q         <= '0;
      strobe_q     <= 1'b0;
      ebus_data_q  <= '0;
      ebus_drive_q <= 1'b0;
      done_q       <= 1'b0;
      mr_done_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values computed above, independent of statement order.
      state_q      <= state_d;
      step_q       <= step_d;
      cnt_q        <= cnt_d;
      is_rom_q     <= is_rom_d;
      mr_pending_q <= mr_pending_d;
      mr_busy_q    <= mr_busy_d;
      func_q       <= func_d;
      data_q       <= data_d;
      data_en_q    <= data_en_d;
      ds_q         <= ds_d;
      strobe_q     <= strobe_d;
      ebus_data_q  <= ebus_data_d;
      ebus_drive_q <= ebus_drive_d;
      done_q       <= done_d;
      mr_done_q    <= mr_done_d;
    end
  end

  //---------------------------------------------------------------------------
  // Outputs: all EBUS lines come straight from registers, so an asserted
  // CROBAR_N clears them immediately without waiting for clk.
  //---------------------------------------------------------------------------
  assign bus.cmdReady   = cmd_ready;
  assign bus.ds         = ds_q;
  assign bus.diagStrobe = strobe_q;
  assign bus.ebusData   = ebus_data_q;
  assign bus.ebusDrive  = ebus_drive_q;
  assign bus.busy       = (state_q != IDLE) || mr_pending_q;
  assign bus.mrBusy     = mr_busy_q || mr_pending_q;
  assign bus.done       = done_q;
  assign bus.mrDone     = mr_done_q;

endmodule

// File: tb/tb_diag_func_sequencer.sv
//-----------------------------------------------------------------------------
// tb_diag_func_sequencer
//
// Self-checking bench for diag_func_sequencer. A schedule model predicts, for
// every clk, the handshake/status/EBUS outputs of the default-parameter
// instance from absolute tick arithmetic; directed literal checks pin the
// model. A second instance with GAP_TICKS=0 covers the zero-gap timing.
//-----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_diag_func_sequencer;

  localparam int S        = 9;
  localparam int G        = 4;
  localparam int S2       = 2;
  localparam int TICK_PER = 3;

`ifdef DIAG_SEQ_KL_ENABLE_EN
  localparam int ROM_LEN = 11;
  localparam logic [6:0] ROM_EXP [ROM_LEN] = '{7'o007, 7'o006, 7'o000, 7'o044,
      7'o046, 7'o042, 7'o043, 7'o052, 7'o051, 7'o067, 7'o076};
`else
  localparam int ROM_LEN = 9;
  localparam logic [6:0] ROM_EXP [ROM_LEN] = '{7'o007, 7'o006, 7'o000, 7'o044,
      7'o046, 7'o042, 7'o043, 7'o052, 7'o051};
`endif

  logic clk      = 1'b0;
  logic CROBAR_N = 1'b0;
  logic tick16   = 1'b0;
  int   cyc      = 0;

  int n_checks = 0;
  int n_errors = 0;

  diag_func_sequencer_if bus ();
  diag_func_sequencer_if bus2 ();

  diag_func_sequencer #(.STROBE_TICKS(S), .GAP_TICKS(G), .CNT_W(4)) dut (
    .clk      (clk),
    .CROBAR_N (CROBAR_N),
    .tick16   (tick16),
    .bus      (bus.slave)
  );

  diag_func_sequencer #(.STROBE_TICKS(S2), .GAP_TICKS(0), .CNT_W(4)) dut_g0 (
    .clk      (clk),
    .CROBAR_N (CROBAR_N),
    .tick16   (tick16),
    .bus      (bus2.slave)
  );

  // 50 MHz clock; tick16 high in every cycle whose index is a multiple of 3.
  initial forever #10 clk = ~clk;

  initial forever begin
    @(posedge clk);
    #1;
    cyc    = cyc + 1;
    tick16 = (cyc % TICK_PER == 0);
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  //---------------------------------------------------------------------------
  // Schedule model: one job at a time. A job accepted (or chained) in cycle a
  // launches at the first tick cycle t > a, strobes in cycles t+1..t+S*P and
  // reports done in cycle t+(S+G)*P+1; the next ROM step chains from there.
  //---------------------------------------------------------------------------
  bit          m_job, m_rom, m_drv, m_pend, m_seq;
  int          m_t, m_d, m_step;
  logic [6:0]  m_func;
  logic [35:0] m_data;

  // Monitor of what the DUT actually put on the bus.
  bit          prev_strobe;
  int          rise_cyc, fall_cyc, strobe_len, done_cyc, done_cnt, mrdone_cnt;
  logic [6:0]  seen_q [$];
  logic [35:0] seen_data;
  bit          seen_drv;

  function automatic int next_tick_after(input int a);
    return (a / TICK_PER + 1) * TICK_PER;
  endfunction

  task automatic start_job(input int a);
    m_job = 1'b1;
    m_t   = next_tick_after(a);
    m_d   = m_t + (S + G) * TICK_PER + 1;
  endtask

  initial begin : compare
    bit e_strobe, e_done;
    logic [6:0] e_ctrl;
    m_job = 0; m_rom = 0; m_drv = 0; m_pend = 0; m_seq = 0; m_step = 0;
    m_t = 0; m_d = 0; m_func = '0; m_data = '0;
    prev_strobe = 0; rise_cyc = 0; fall_cyc = 0; strobe_len = 0;
    done_cyc = 0; done_cnt = 0; mrdone_cnt = 0; seen_data = '0; seen_drv = 0;
    forever begin
      @(negedge clk);
      if (!CROBAR_N) begin
        m_job = 0; m_pend = 0; m_seq = 0; m_rom = 0;
      end
      e_strobe = m_job && (cyc > m_t) && (cyc <= m_t + S * TICK_PER);
      e_done   = m_job && (cyc == m_d);
      e_ctrl   = {!m_job && !m_pend, m_job || m_pend, m_seq || m_pend, e_done,
                  e_done && m_rom && (m_step == ROM_LEN - 1), e_strobe, e_strobe && m_drv};
      check("ctrl{rdy,busy,mrbusy,done,mrdone,strobe,drive}",
            64'({bus.cmdReady, bus.busy, bus.mrBusy, bus.done, bus.mrDone,
                 bus.diagStrobe, bus.ebusDrive}), 64'(e_ctrl));
      check("ds", 64'(bus.ds), 64'(e_strobe ? m_func : 7'd0));
      check("ebus_data", 64'(bus.ebusData), 64'((e_strobe && m_drv) ? m_data : 36'd0));

      if (bus.diagStrobe && !prev_strobe) begin
        rise_cyc  = cyc;
        seen_data = bus.ebusData;
        seen_drv  = bus.ebusDrive;
        seen_q.push_back(bus.ds);
      end
      if (!bus.diagStrobe && prev_strobe) begin
        fall_cyc   = cyc;
        strobe_len = cyc - rise_cyc;
      end
      prev_strobe = bus.diagStrobe;
      if (bus.done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (bus.mrDone) mrdone_cnt++;

      if (CROBAR_N) begin
        if (m_job) begin
          if (bus.mrStart) m_pend = 1'b1;
          if (cyc == m_d) begin
            if (m_rom && m_step < ROM_LEN - 1) begin
              m_step++;
              m_func = ROM_EXP[m_step];
              start_job(cyc);
            end else begin
              m_job = 1'b0;
              if (m_rom) m_seq = 1'b0;
            end
          end
        end else if (bus.mrStart || m_pend) begin
          m_pend = 1'b0; m_seq = 1'b1; m_rom = 1'b1; m_step = 0;
          m_func = ROM_EXP[0]; m_data = '0; m_drv = 1'b0;
          start_job(cyc);
        end else if (bus.cmdValid) begin
          m_rom = 1'b0; m_func = bus.cmdFunc; m_data = bus.cmdData; m_drv = bus.cmdDataEn;
          start_job(cyc);
        end
      end
    end
  end

  //---------------------------------------------------------------------------
  // Stimulus helpers
  //---------------------------------------------------------------------------
  task automatic issue_cmd(input logic [6:0] func, input logic [35:0] data, input logic den);
    @(posedge clk); #1;
    bus.cmdValid = 1'b1; bus.cmdFunc = func; bus.cmdData = data; bus.cmdDataEn = den;
    @(posedge clk); #1;
    bus.cmdValid = 1'b0; bus.cmdDataEn = 1'b0;
  endtask

  task automatic pulse_mr();
    @(posedge clk); #1 bus.mrStart = 1'b1;
    @(posedge clk); #1 bus.mrStart = 1'b0;
  endtask

  // which: 0 = diagStrobe high, 1 = done count reached, 2 = mrDone count reached
  task automatic wait_until(input string name, input int which, input int target, input int budget);
    bit hit = 1'b0;
    for (int k = 0; k < budget && !hit; k++) begin
      @(negedge clk); #1;
      case (which)
        0:       hit = bus.diagStrobe;
        1:       hit = (done_cnt >= target);
        default: hit = (mrdone_cnt >= target);
      endcase
    end
    if (!hit) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: timed out after %0d cycles, got no event, expected event", name, budget);
    end
  endtask

  //---------------------------------------------------------------------------
  // Directed sequence
  //---------------------------------------------------------------------------
  initial begin : stim
    int d0, m0, q0, acc, r, f, dn;
    logic [6:0] r_ds;
    bus.cmdValid = 0; bus.cmdFunc = '0; bus.cmdData = '0; bus.cmdDataEn = 0; bus.mrStart = 0;
    bus2.cmdValid = 0; bus2.cmdFunc = '0; bus2.cmdData = '0; bus2.cmdDataEn = 0; bus2.mrStart = 0;

    // Reset state
    CROBAR_N = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ds", 64'(bus.ds), 64'd0);
    check("rst_strobe_busy_mrbusy_done", 64'({bus.diagStrobe, bus.busy, bus.mrBusy, bus.done, bus.mrDone}), 64'd0);
    @(posedge clk); #1 CROBAR_N = 1'b1;
    @(negedge clk);
    check("ready_after_rst", 64'(bus.cmdReady), 64'd1);

    // Single command 001
    d0 = done_cnt;
    issue_cmd(7'o001, 36'd0, 1'b0);
    wait_until("t1_done", 1, d0 + 1, 200);
    check("t1_strobe_len", 64'(strobe_len), 64'd27);
    check("t1_ds", 64'(seen_q[$]), 64'(7'o001));
    check("t1_release_to_done", 64'(done_cyc - fall_cyc), 64'd12);
    @(negedge clk);
    check("t1_ready_next", 64'(bus.cmdReady), 64'd1);

    // Load command 076 with data
    d0 = done_cnt;
    issue_cmd(7'o076, 36'o123456701234, 1'b1);
    wait_until("t2_done", 1, d0 + 1, 200);
    check("t2_data", 64'(seen_data), 64'(36'o123456701234));
    check("t2_drive", 64'(seen_drv), 64'd1);
    check("t2_ds", 64'(seen_q[$]), 64'(7'o076));
    check("t2_drive_after", 64'({bus.ebusDrive, bus.ebusData}), 64'd0);

    // Master reset alone
    q0 = seen_q.size(); d0 = done_cnt; m0 = mrdone_cnt;
    pulse_mr();
    wait_until("t3_mrdone", 2, m0 + 1, 2000);
    check("t3_strobes", 64'(seen_q.size() - q0), 64'(ROM_LEN));
    check("t3_dones", 64'(done_cnt - d0), 64'(ROM_LEN));
    for (int i = 0; i < ROM_LEN; i++) check("t3_rom_code", 64'(seen_q[q0 + i]), 64'(ROM_EXP[i]));
    @(negedge clk);
    check("t3_mrdone_count", 64'(mrdone_cnt - m0), 64'd1);
    check("t3_mrbusy_clear", 64'(bus.mrBusy), 64'd0);

    // Collision: master reset during the strobe of command 000
    q0 = seen_q.size(); m0 = mrdone_cnt;
    issue_cmd(7'o000, 36'd0, 1'b0);
    wait_until("t4_strobe", 0, 0, 100);
    pulse_mr();
    @(negedge clk);
    check("t4_ready_blocked", 64'({bus.cmdReady, bus.mrBusy}), 64'b01);
    wait_until("t4_mrdone", 2, m0 + 1, 2000);
    check("t4_cmd_first", 64'(seen_q[q0]), 64'(7'o000));
    check("t4_rom_first", 64'(seen_q[q0 + 1]), 64'(7'o007));
    check("t4_strobes", 64'(seen_q.size() - q0), 64'(ROM_LEN + 1));

    // Simultaneous cmdValid and mrStart in IDLE: ROM wins, command dropped
    q0 = seen_q.size(); m0 = mrdone_cnt;
    @(posedge clk); #1;
    bus.cmdValid = 1'b1; bus.cmdFunc = 7'o005; bus.mrStart = 1'b1;
    @(posedge clk); #1;
    bus.cmdValid = 1'b0; bus.mrStart = 1'b0;
    wait_until("t5_mrdone", 2, m0 + 1, 2000);
    check("t5_rom_first", 64'(seen_q[q0]), 64'(7'o007));
    check("t5_strobes", 64'(seen_q.size() - q0), 64'(ROM_LEN));

    // Edge timing: acceptance coincides with a tick
    repeat (2) @(negedge clk);
    for (int k = 0; k < 10 && ((cyc + 1) % TICK_PER != 0); k++) @(negedge clk);
    d0 = done_cnt;
    @(posedge clk); #1;
    bus.cmdValid = 1'b1; bus.cmdFunc = 7'o003;
    @(negedge clk);
    acc = cyc;
    @(posedge clk); #1 bus.cmdValid = 1'b0;
    wait_until("t6_done", 1, d0 + 1, 200);
    check("t6_launch_delay", 64'(rise_cyc - acc), 64'd4);
    check("t6_ds", 64'(seen_q[$]), 64'(7'o003));

    // Asynchronous reset mid-strobe with a master reset pending
    issue_cmd(7'o002, 36'd0, 1'b0);
    wait_until("t7_strobe", 0, 0, 100);
    pulse_mr();
    @(posedge clk); #5 CROBAR_N = 1'b0;
    #1;
    check("t7_async_clear", 64'({bus.diagStrobe, bus.ds, bus.busy}), 64'd0);
    @(posedge clk); #1 CROBAR_N = 1'b1;
    @(negedge clk);
    check("t7_ready_after", 64'({bus.cmdReady, bus.mrBusy, bus.busy}), 64'b100);
    q0 = seen_q.size();
    repeat (60) @(negedge clk);
    check("t7_no_restart", 64'(seen_q.size() - q0), 64'd0);

    // Zero-gap instance: done in the clk right after the release tick
    @(posedge clk); #1;
    bus2.cmdValid = 1'b1; bus2.cmdFunc = 7'o011;
    @(posedge clk); #1 bus2.cmdValid = 1'b0;
    r = -1; f = -1; dn = -1; r_ds = '0;
    for (int k = 0; k < 100 && dn < 0; k++) begin
      @(negedge clk);
      if (bus2.diagStrobe && r < 0) begin r = cyc; r_ds = bus2.ds; end
      if (!bus2.diagStrobe && r >= 0 && f < 0) f = cyc;
      if (bus2.done) dn = cyc;
    end
    if (dn < 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL g0_done: timed out, got no done, expected done");
    end else begin
      check("g0_strobe_len", 64'(f - r), 64'd6);
      check("g0_done_after_release", 64'(dn - f), 64'd0);
      check("g0_ds", 64'(r_ds), 64'(7'o011));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/diag_func_sequencer.md
Name: diag_func_sequencer

Overview:
- Hardware front-end sequencer for EBUS diagnostic functions (CLK, CTL, etc.).
- Replaces bench-driven task sequencing with a synthesizable FSM that drives `EBUS.ds[0:6]`, `EBUS.diagStrobe` and optional `EBUS.data`, all timed by the 16 MHz free-running clock.
- Accepts single function requests from a front-end port.
- Contains a built-in master-reset sequence ROM: stop clock, clear source/rate, reset parity, clear burst and CRAM diagnostic address.

Parameters:
- STROBE_TICKS, 9: number of MHZ16 tick periods that diagStrobe is held high (min 1).
- GAP_TICKS, 4: tick periods of idle bus after strobe release, before completion (min 0).
- CNT_W, 4: width of the tick counter; must hold max(STROBE_TICKS, GAP_TICKS).

Ports:
- clk  in  1  EBOX master clock, 50 MHz.
- CROBAR_N  in  1  asynchronous active-low reset.
- tick16  in  1  one-clk pulse, derived from the falling edge of CLK.MHZ16_FREE.
- cmdValid  in  1  front end requests a single diagnostic function.
- cmdReady  out  1  sequencer can accept a command.
- cmdFunc  in  7  diagnostic function code, octal 000-177.
- cmdData  in  36  EBUS data for load-type functions.
- cmdDataEn  in  1  drive cmdData onto EBUS during the strobe.
- mrStart  in  1  one-clk pulse requesting the master-reset sequence.
- ds  out  7  EBUS.ds[0:6].
- diagStrobe  out  1  EBUS.diagStrobe.
- ebusData  out  36  EBUS data value.
- ebusDrive  out  1  EBUS data driver enable.
- busy  out  1  high whenever state is not IDLE or a master reset is pending.
- mrBusy  out  1  master-reset sequence in progress or pending.
- done  out  1  one-clk pulse per completed function.
- mrDone  out  1  one-clk pulse when the last ROM step completes.

Behaviour:
- Reset (CROBAR_N low, asynchronous), effective immediately mid-operation:
  - State IDLE.
  - ds=0, diagStrobe=0, ebusData=0, ebusDrive=0.
  - done=0, mrDone=0, busy=0, mrBusy=0.
  - mrPending=0, step index=0, counter=0.
  - cmdReady=1 once reset is released.
- States: IDLE -> SETUP -> STROBE -> GAP -> FINISH -> (IDLE | SETUP).
- IDLE:
  - cmdReady = !mrPending.
  - mrStart or mrPending set: load ROM step 0, mrBusy=1, go to SETUP. Master reset wins over a simultaneous cmdValid.
  - Otherwise, cmdValid && cmdReady: latch cmdFunc, cmdData and cmdDataEn; go to SETUP.
- SETUP:
  - Waits for the next tick16; a tick in the acceptance cycle itself does not count.
  - On that tick: ds=func, ebusData/ebusDrive per the latched data enable, diagStrobe=1, counter=0; go to STROBE.
- STROBE:
  - Each tick16 increments counter.
  - On the tick where counter reaches STROBE_TICKS: clear diagStrobe, ds, ebusDrive and ebusData in the same clk.
  - Then go to GAP with counter=0; if GAP_TICKS=0, go directly to FINISH.
- GAP: counts GAP_TICKS ticks; the clk of the final tick goes to FINISH.
- FINISH (one clk):
  - Single command: done=1, then IDLE.
  - ROM step: done=1; if this was the last step, mrDone=1, clear mrBusy, go to IDLE; else step+1, go to SETUP.
- mrStart while busy: sets sticky mrPending; sequence starts on return to IDLE. A second mrStart while pending has no further effect.
- cmdReady=0 in every state except IDLE. cmdValid outside IDLE is ignored; requesters must hold it.
- Master-reset ROM, octal, in order: 007 SET_RESET, 006 CLR_RESET, 000 STOP_CLOCK, 044 CLR_CLK_SRC_RATE, 046 RESET_PAR_REGS, 042 CLR_BURST_CTR_RH, 043 CLR_BURST_CTR_LH, 052 CLR_CRAM_DIAG_ADR_LH, 051 CLR_CRAM_DIAG_ADR_RH.
- ROM steps never drive data (ebusDrive=0).
- Timing: with tick period T, each function occupies at most T + STROBE_TICKS*T + GAP_TICKS*T + 1 clk from acceptance to done.
- ds and ebusData change only on tick16 clks, so they are stable for the full strobe.

Optional Feature:
- DIAG_SEQ_KL_ENABLE_EN defined: ROM is extended to 11 steps by appending 067 ENABLE_KL, then 076 EBUS_LOAD. mrDone fires after 076.
- DIAG_SEQ_KL_ENABLE_EN undefined: ROM has 9 steps and ends at 051.

Test Plan:
- Single command: tick16 every 3 clk, cmdFunc=001, STROBE_TICKS=9, GAP_TICKS=4. Expect:
  - diagStrobe high for exactly 27 clk.
  - ds=001 throughout the strobe, ds=0 after.
  - done one clk after the 4th gap tick.
  - cmdReady high the next clk.
- Load command: cmdFunc=076, cmdDataEn=1, cmdData=36'o123456701234. Expect ebusDrive=1 and ebusData equal to that value only while diagStrobe=1; both 0 at release.
- Master reset: pulse mrStart with no other activity. Expect:
  - Exactly 9 strobes with ds sequence 007,006,000,044,046,042,043,052,051.
  - 9 done pulses, one mrDone after the last.
  - mrBusy high throughout.
  - With DIAG_SEQ_KL_ENABLE_EN: 11 strobes ending 067,076.
- Collision: mrStart during the STROBE of a cmdFunc=000 command. Expect:
  - The command completes, then the master-reset sequence starts.
  - cmdReady=0 until mrDone.
  - Simultaneous cmdValid and mrStart in IDLE: ROM step 007 is issued first.
- Asynchronous reset: assert CROBAR_N low mid-STROBE. Expect diagStrobe=0, ds=0 and busy=0 in the same cycle, without waiting for a clk edge. After release: cmdReady=1 and mrPending cleared.
- Edge timing: tick16 in the same clk as acceptance. Expect the strobe to assert at the following tick, not that one. With GAP_TICKS=0, done follows the release tick by one clk.
